// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/D requesters, the arbiter and the single-port cache array.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port cache array: D has priority, IF is forced
// after STARVE_LIMIT consecutive D wins; fixed-latency req/gnt/rvalid, all outputs registered.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_owner_d;
  logic [SC_W-1:0]   r_starve;
  logic [LAT_W-1:0]  r_lat;

  logic              r_if_gnt;
  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_d_gnt;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;

  logic              w_if_starved;
  logic              w_pick_d;
  logic              w_pick_if;

  always_comb begin
    w_if_starved = bus.if_req && (r_starve == SC_MAX);
    w_pick_d     = bus.d_req && !w_if_starved;
    w_pick_if    = bus.if_req && !w_pick_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_owner_d   <= 1'b0;
      r_starve    <= '0;
      r_lat       <= '0;
      r_if_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_gnt     <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_d) begin
            r_state     <= S_ISSUE;
            r_owner_d   <= 1'b1;
            r_d_gnt     <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_busy      <= 1'b1;
            if (!bus.if_req)
              r_starve <= '0;
            else if (r_starve != SC_MAX)
              r_starve <= r_starve + 1'b1;
          end else if (w_pick_if) begin
            r_state     <= S_ISSUE;
            r_owner_d   <= 1'b0;
            r_if_gnt    <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
            r_busy      <= 1'b1;
            r_starve    <= '0;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_lat   <= LAT_INIT;
        end
        S_WAIT: begin
          // rvalid/rdata are loaded here so they are registered during the RESP cycle
          if (r_lat == '0) begin
            r_state <= S_RESP;
            if (r_owner_d) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= r_mem_we ? '0 : bus.mem_rdata;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= bus.mem_rdata;
            end
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_gnt    = r_if_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_gnt     = r_d_gnt;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at MEM_LATENCY=1 and one at MEM_LATENCY=3, each with a small array model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  // Array models: contents reload while rst is low (m1[i]=i+1, m3[i]=i+10).
  logic [31:0] m1 [16];
  logic [31:0] m3 [16];
  logic [31:0] p3a, p3b;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) m1[i] <= 32'(i) + 32'd1;
    end else if (b1.mem_en && b1.mem_we) begin
      m1[b1.mem_addr[3:0]] <= b1.mem_wdata;
    end
    b1.mem_rdata <= m1[b1.mem_addr[3:0]];
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) m3[i] <= 32'(i) + 32'd10;
    end else if (b3.mem_en && b3.mem_we) begin
      m3[b3.mem_addr[3:0]] <= b3.mem_wdata;
    end
    p3a          <= m3[b3.mem_addr[3:0]];
    p3b          <= p3a;
    b3.mem_rdata <= p3b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds both requests on dut1 and checks the grant order (bit k set = grant k goes to IF).
  task automatic run_starve(input string tag, input int n, input logic [15:0] exp_if);
    int k;
    k = 0;
    b1.if_req = 1'b1; b1.if_addr = 32'd1;
    b1.d_req  = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'd2;
    for (int cyc = 0; cyc < 120 && k < n; cyc++) begin
      step();
      if (b1.if_gnt || b1.d_gnt) begin
        chk($sformatf("%s_grant%0d", tag, k), {30'd0, b1.if_gnt, b1.d_gnt},
            exp_if[k] ? 32'd2 : 32'd1);
        k++;
      end
    end
    chk({tag, "_count"}, k, n);
    b1.if_req = 1'b0;
    b1.d_req  = 1'b0;
    for (int cyc = 0; cyc < 20 && b1.busy; cyc++) step();
    chk({tag, "_drain"}, {31'd0, b1.busy}, 32'd0);
  endtask

  initial begin
    b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0;

    repeat (3) step();
    chk("rst_strobes1", {25'd0, b1.if_gnt, b1.if_rvalid, b1.d_gnt, b1.d_rvalid, b1.mem_en, b1.mem_we, b1.busy}, 32'd0);
    chk("rst_strobes3", {25'd0, b3.if_gnt, b3.if_rvalid, b3.d_gnt, b3.d_rvalid, b3.mem_en, b3.mem_we, b3.busy}, 32'd0);
    chk("rst_buses1", b1.mem_addr | b1.mem_wdata | b1.if_rdata | b1.d_rdata, 32'd0);
    rst = 1'b1;

    // IF read of address 4 (holds 5), latency 1
    b1.if_req = 1'b1; b1.if_addr = 32'd4;
    step();
    chk("if_gnt", {28'd0, b1.if_gnt, b1.mem_en, b1.mem_we, b1.d_gnt}, 32'hC);
    chk("if_addr", b1.mem_addr, 32'd4);
    chk("if_busy1", {31'd0, b1.busy}, 32'd1);
    step();
    b1.if_req = 1'b0;
    chk("if_wait", {29'd0, b1.if_gnt, b1.mem_en, b1.if_rvalid}, 32'd0);
    chk("if_busy2", {31'd0, b1.busy}, 32'd1);
    step();
    chk("if_rvalid", {30'd0, b1.if_rvalid, b1.busy}, 32'd3);
    chk("if_rdata", b1.if_rdata, 32'd5);
    step();
    chk("if_done", {30'd0, b1.if_rvalid, b1.busy}, 32'd0);

    // D write of 0xAB to address 2, payload changed after grant
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'd2; b1.d_wdata = 32'hAB;
    step();
    chk("dw_gnt", {29'd0, b1.d_gnt, b1.mem_en, b1.mem_we}, 32'd7);
    chk("dw_wdata", b1.mem_wdata, 32'hAB);
    chk("dw_addr", b1.mem_addr, 32'd2);
    step();
    b1.d_req = 1'b0; b1.d_wdata = 32'hFF; b1.d_addr = 32'd9;
    chk("dw_hold_wdata", b1.mem_wdata, 32'hAB);
    chk("dw_hold_addr", b1.mem_addr, 32'd2);
    step();
    chk("dw_rvalid", {31'd0, b1.d_rvalid}, 32'd1);
    chk("dw_rdata_zero", b1.d_rdata, 32'd0);
    step();
    chk("dw_done", {31'd0, b1.d_rvalid}, 32'd0);
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'd2;
    step();
    chk("dr_gnt", {29'd0, b1.d_gnt, b1.mem_en, b1.mem_we}, 32'd6);
    step();
    b1.d_req = 1'b0;
    step();
    chk("dr_rvalid", {31'd0, b1.d_rvalid}, 32'd1);
    chk("dr_rdata", b1.d_rdata, 32'hAB);
    chk("if_rdata_kept", b1.if_rdata, 32'd5);
    step();

    // Simultaneous requests: D first, IF next once D drops
    b1.if_req = 1'b1; b1.if_addr = 32'd4;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'd3;
    step();
    chk("sim_first", {30'd0, b1.if_gnt, b1.d_gnt}, 32'd1);
    step();
    b1.d_req = 1'b0;
    step();
    chk("sim_d_rdata", b1.d_rdata, 32'd4);
    chk("sim_no_if", {31'd0, b1.if_gnt}, 32'd0);
    step();
    step();
    chk("sim_second", {30'd0, b1.if_gnt, b1.d_gnt}, 32'd2);
    chk("sim_if_addr", b1.mem_addr, 32'd4);
    step();
    b1.if_req = 1'b0;
    step();
    chk("sim_if_rdata", {b1.if_rdata[30:0], b1.if_rvalid}, {31'd5, 1'b1});
    step();

    // Starvation guard: D,D,D,D,IF,D,D,D,D,IF
    run_starve("starve", 10, 16'b0000_0010_0001_0000);

    // Latency 3 D read of address 7 (holds 0x11)
    b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'd7;
    step();
    chk("l3_gnt", {30'd0, b3.d_gnt, b3.mem_en}, 32'd3);
    chk("l3_addr", b3.mem_addr, 32'd7);
    step();
    b3.d_req = 1'b0;
    step();
    step();
    chk("l3_not_yet", {30'd0, b3.d_rvalid, b3.busy}, 32'd1);
    step();
    chk("l3_rvalid", {31'd0, b3.d_rvalid}, 32'd1);
    chk("l3_rdata", b3.d_rdata, 32'h11);
    step();
    chk("l3_done", {30'd0, b3.d_rvalid, b3.busy}, 32'd0);

    // Reset during WAIT on dut3, with dut1 starvation count left at 1
    b1.if_req = 1'b1; b1.d_req = 1'b1; b1.d_we = 1'b0;
    b3.if_req = 1'b1; b3.if_addr = 32'd7;
    step();
    chk("pre_rst_gnt", {30'd0, b1.d_gnt, b3.if_gnt}, 32'd3);
    step();
    b3.if_req = 1'b0;
    step();
    chk("pre_rst_busy", {31'd0, b3.busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_async3", {24'd0, b3.if_gnt, b3.if_rvalid, b3.d_gnt, b3.d_rvalid, b3.mem_en, b3.mem_we, b3.busy, b1.busy}, 32'd0);
    chk("rst_addr3", b3.mem_addr, 32'd0);
    chk("rst_drdata3", b3.d_rdata, 32'd0);
    b1.if_req = 1'b0; b1.d_req = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_rst_quiet%0d", i), {29'd0, b3.if_rvalid, b3.busy, b3.mem_en}, 32'd0);
    end
    b3.if_req = 1'b1; b3.if_addr = 32'd7;
    step();
    chk("post_rst_gnt", {30'd0, b3.if_gnt, b3.mem_en}, 32'd3);
    step();
    b3.if_req = 1'b0;
    step();
    step();
    step();
    chk("post_rst_rvalid", {31'd0, b3.if_rvalid}, 32'd1);
    chk("post_rst_rdata", b3.if_rdata, 32'h11);
    step();

    // Starvation count must restart from zero after reset
    run_starve("starve_rst", 5, 16'b0000_0000_0001_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port cache array between two requesters: instruction fetch (IF) and load/store (D).
- Serialises accesses through a fixed-latency req/gnt/rvalid handshake.
- Owns the array's control inputs: enable, write-enable, address, write data.
- Fixed priority to D, plus a starvation guard that forces an IF grant after a bounded number of consecutive D wins.

Parameters:
- ADDR_W, 32, address width, all ports.
- DATA_W, 32, data width, all ports.
- MEM_LATENCY, 1, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..8.
- STARVE_LIMIT, 4, consecutive D grants with IF pending before IF is forced; legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  IF request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  IF read address.
- if_gnt  out  1  one-cycle IF grant pulse.
- if_rvalid  out  1  one-cycle IF read-data-valid pulse.
- if_rdata  out  DATA_W  IF read data; valid when if_rvalid=1.
- d_req  in  1  D request; held with d_we, d_addr, d_wdata until d_gnt.
- d_we  in  1  0 read, 1 write.
- d_addr  in  ADDR_W  D address.
- d_wdata  in  DATA_W  D write data.
- d_gnt  out  1  one-cycle D grant pulse.
- d_rvalid  out  1  one-cycle D completion pulse, reads and writes.
- d_rdata  out  DATA_W  D read data; 0 on write completion.
- mem_en  out  1  array access strobe, one cycle per transaction.
- mem_we  out  1  array write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  array address.
- mem_wdata  out  DATA_W  array write data.
- mem_rdata  in  DATA_W  array read data, MEM_LATENCY cycles after mem_en.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, owner=IF, starve_cnt=0, lat_cnt=0.
  - All outputs 0, including if_rdata, d_rdata, mem_addr, mem_wdata.
  - Any in-flight transaction is dropped: no rvalid, no further mem_en.
- Registered outputs: all outputs are registered; none depends combinationally on inputs.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, sampling requests at the edge ending cycle T:
  - Winner rule: D wins if d_req=1, unless if_req=1 and starve_cnt==STARVE_LIMIT; otherwise IF wins if if_req=1.
  - On a winner, go to ISSUE; in cycle T+1:
    - winner's gnt=1 and mem_en=1;
    - mem_we = d_we for D, 0 for IF;
    - mem_addr and mem_wdata carry the winner's payload, captured at edge T (mem_wdata=0 for IF).
  - No request: stay in IDLE, all strobes 0.
- starve_cnt updates at each grant decision:
  - D granted while if_req=1: increment, saturating at STARVE_LIMIT.
  - IF granted: clear to 0.
  - D granted with if_req=0: clear to 0.
- ISSUE (one cycle):
  - Next state WAIT; lat_cnt=MEM_LATENCY-1.
  - gnt and mem_en fall after this cycle; mem_addr/mem_we/mem_wdata hold until the next ISSUE.
- WAIT:
  - Decrement lat_cnt each cycle; at lat_cnt==0, capture mem_rdata into the owner's rdata register and go to RESP.
  - Capture cycle = T+1+MEM_LATENCY.
- RESP (one cycle, T+2+MEM_LATENCY):
  - Owner's rvalid=1.
  - For a D write, d_rdata=0 and the array read data is ignored.
  - Next state IDLE. The non-owner's rdata register is unchanged.
- Occupancy: each transaction occupies MEM_LATENCY+3 cycles from request sampling to the return to IDLE. Requests are ignored outside IDLE.
- Requester rules:
  - Requester deasserts req no earlier than the cycle after gnt.
  - req still high in IDLE after completion is treated as a new request.
  - A req dropped before gnt is legal; it simply is not granted.
- Payload capture: payload is captured only at the grant edge; changes afterwards have no effect.
- Simultaneous events: if_req and d_req rising in the same cycle resolve by the winner rule; the loser stays pending.
- Overflow: starve_cnt is clog2(STARVE_LIMIT+1) bits and never exceeds STARVE_LIMIT.

Test Plan:
- IF read, MEM_LATENCY=1, array[4]=5: if_req with if_addr=4 sampled cycle 0 -> if_gnt, mem_en, mem_addr=4, mem_we=0 in cycle 1; if_rvalid=1 with if_rdata=5 in cycle 3; busy cycles 1–3.
- D write then read: write d_addr=2, d_wdata=0xAB -> mem_we=1 and mem_wdata=0xAB in the grant cycle; d_rvalid with d_rdata=0 two cycles later; following read of address 2 returns 0xAB.
- Simultaneous if_req=1, d_req=1 in cycle 0 -> d_gnt first; IF granted on the next IDLE sample once d_req is dropped.
- Starvation, STARVE_LIMIT=4, if_req and d_req both held continuously -> grant order D,D,D,D,IF,D,D,D,D,IF.
- MEM_LATENCY=3, D read of address 7 holding 0x11 -> d_gnt cycle 1; mem_rdata sampled cycle 4; d_rvalid=1 with d_rdata=0x11 cycle 5.
- rst pulsed low during WAIT -> all outputs 0 immediately, no rvalid; after release, a fresh if_req is granted normally with starve_cnt=0.
